// File: rtl/ob_mk_trade_seq_if.sv
// ob_mk_trade_seq_if
// Bundles the sequencer's ownership handshake, trade-decision query/result,
// table-update command and egress trade-record channels.
//   master : the sequencer side (drives mk_req/mk_done, trade_qry, upd_*, rsp_*,
//            trade_cnt, err_r)
//   slave  : the surrounding controller / decision logic / table / egress side
interface ob_mk_trade_seq_if #(
  parameter int UID_W   = 32,
  parameter int QTY_W   = 16,
  parameter int PRICE_W = 20
);
  // ownership handshake with the top-level controller
  logic               mk_pending;
  logic               mk_req;
  logic               mk_gnt;
  logic               mk_done;
  // trade decision query / registered result
  logic               trade_qry;
  logic               trade_vld_r;
  logic [2:0]         trade_kind;
  logic [UID_W-1:0]   ask_uid;
  logic [UID_W-1:0]   bid_uid;
  logic [PRICE_W-1:0] ask_price;
  logic [PRICE_W-1:0] bid_price;
  logic               ask_consumed;
  logic               bid_consumed;
  logic [QTY_W-1:0]   quantity;
  logic [QTY_W-1:0]   remainder;
  // table / queue update command
  logic               upd_vld;
  logic               upd_ack;
  logic               upd_pop_ask;
  logic               upd_pop_bid;
  logic               upd_ask_lm;
  logic               upd_bid_lm;
  logic               upd_rem_vld;
  logic [QTY_W-1:0]   upd_rem;
  // egress trade record
  logic               rsp_vld;
  logic               rsp_accept;
  logic [UID_W-1:0]   rsp_ask_uid;
  logic [UID_W-1:0]   rsp_bid_uid;
  logic [PRICE_W-1:0] rsp_price;
  logic [QTY_W-1:0]   rsp_quantity;
  // status
  logic [31:0]        trade_cnt;
  logic               err_r;

  modport master (
    input  mk_pending, mk_gnt, trade_vld_r, trade_kind, ask_uid, bid_uid,
           ask_price, bid_price, ask_consumed, bid_consumed, quantity, remainder,
           upd_ack, rsp_accept,
    output mk_req, mk_done, trade_qry, upd_vld, upd_pop_ask, upd_pop_bid,
           upd_ask_lm, upd_bid_lm, upd_rem_vld, upd_rem, rsp_vld, rsp_ask_uid,
           rsp_bid_uid, rsp_price, rsp_quantity, trade_cnt, err_r
  );

  modport slave (
    output mk_pending, mk_gnt, trade_vld_r, trade_kind, ask_uid, bid_uid,
           ask_price, bid_price, ask_consumed, bid_consumed, quantity, remainder,
           upd_ack, rsp_accept,
    input  mk_req, mk_done, trade_qry, upd_vld, upd_pop_ask, upd_pop_bid,
           upd_ask_lm, upd_bid_lm, upd_rem_vld, upd_rem, rsp_vld, rsp_ask_uid,
           rsp_bid_uid, rsp_price, rsp_quantity, trade_cnt, err_r
  );
endinterface

// File: rtl/ob_mk_trade_seq.sv
// ob_mk_trade_seq
// Market-order trade sequencer. Requests table ownership, issues trade
// queries to the decision logic, captures each registered result, then
// issues the table update and the egress trade record in parallel (each with
// its own handshake). Runs up to BURST_N trades per grant before releasing.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - ob_mk_trade_seq_if master modport (all handshake/data channels)
// All outputs are registered.
module ob_mk_trade_seq #(
  parameter int UID_W   = 32,
  parameter int QTY_W   = 16,
  parameter int PRICE_W = 20,
  parameter int BURST_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  ob_mk_trade_seq_if.master bus
);

  localparam int              BC_W      = $clog2(BURST_N + 1);
  localparam logic [BC_W-1:0] BURST_LIM = BC_W'(BURST_N);

  typedef enum logic [2:0] {IDLE, REQ, QRY, WAIT, EMIT, REL} state_t;

  state_t             state_q, state_nx;
  logic [BC_W-1:0]    burst_q, burst_nx, burst_inc;
  logic [31:0]        cnt_q, cnt_nx;
  logic               err_q, err_nx;
  logic               upd_done_q, upd_done_nx;
  logic               rsp_done_q, rsp_done_nx;
  logic               capture;
  logic               kind_ok;
  logic               upd_hs, rsp_hs;

  logic               mk_req_q, mk_req_nx;
  logic               mk_done_q, mk_done_nx;
  logic               trade_qry_q, trade_qry_nx;
  logic               upd_vld_q, upd_vld_nx;
  logic               rsp_vld_q, rsp_vld_nx;

  // held trade, stored directly in output form
  logic               pop_ask_q, pop_bid_q, ask_lm_q, bid_lm_q, rem_vld_q;
  logic [QTY_W-1:0]   rem_q, qty_q;
  logic [UID_W-1:0]   ask_uid_q, bid_uid_q;
  logic [PRICE_W-1:0] price_q;

  always_comb begin
    state_nx    = state_q;
    burst_nx    = burst_q;
    cnt_nx      = cnt_q;
    err_nx      = err_q;
    upd_done_nx = upd_done_q;
    rsp_done_nx = rsp_done_q;
    capture     = 1'b0;
    kind_ok     = (bus.trade_kind == 3'b001) || (bus.trade_kind == 3'b010) ||
                  (bus.trade_kind == 3'b100);
    upd_hs      = upd_vld_q && bus.upd_ack;
    rsp_hs      = rsp_vld_q && bus.rsp_accept;
    burst_inc   = burst_q + BC_W'(1);

    case (state_q)
      IDLE: if (bus.mk_pending) state_nx = REQ;
      REQ:  if (bus.mk_gnt) state_nx = QRY;
      QRY:  state_nx = WAIT;
      WAIT: begin
        if (bus.trade_vld_r) begin
          if (!kind_ok || !(bus.ask_consumed || bus.bid_consumed)) begin
            err_nx   = 1'b1;
            state_nx = REL;
          end else begin
            capture     = 1'b1;
            upd_done_nx = 1'b0;
            rsp_done_nx = 1'b0;
            state_nx    = EMIT;
          end
        end else begin
          state_nx = REL;
        end
      end
      EMIT: begin
        // a channel counts as done in the same cycle its handshake occurs
        upd_done_nx = upd_done_q || upd_hs;
        rsp_done_nx = rsp_done_q || rsp_hs;
        if (upd_done_nx && rsp_done_nx) begin
          cnt_nx   = cnt_q + 32'd1;
          burst_nx = burst_inc;
          state_nx = ((burst_inc < BURST_LIM) && bus.mk_pending) ? QRY : REL;
        end
      end
      REL: begin
        burst_nx = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // outputs are registered, so they are decoded from the next state
    mk_req_nx    = (state_nx == REQ) || (state_nx == QRY) ||
                   (state_nx == WAIT) || (state_nx == EMIT);
    mk_done_nx   = (state_nx == REL);
    trade_qry_nx = (state_nx == QRY);
    upd_vld_nx   = (state_nx == EMIT) && (capture || (upd_vld_q && !bus.upd_ack));
    rsp_vld_nx   = (state_nx == EMIT) && (capture || (rsp_vld_q && !bus.rsp_accept));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      upd_done_q  <= 1'b0;
      rsp_done_q  <= 1'b0;
      mk_req_q    <= 1'b0;
      mk_done_q   <= 1'b0;
      trade_qry_q <= 1'b0;
      upd_vld_q   <= 1'b0;
      rsp_vld_q   <= 1'b0;
      pop_ask_q   <= 1'b0;
      pop_bid_q   <= 1'b0;
      ask_lm_q    <= 1'b0;
      bid_lm_q    <= 1'b0;
      rem_vld_q   <= 1'b0;
      rem_q       <= '0;
      qty_q       <= '0;
      ask_uid_q   <= '0;
      bid_uid_q   <= '0;
      price_q     <= '0;
    end else begin
      state_q     <= state_nx;
      burst_q     <= burst_nx;
      cnt_q       <= cnt_nx;
      err_q       <= err_nx;
      upd_done_q  <= upd_done_nx;
      rsp_done_q  <= rsp_done_nx;
      mk_req_q    <= mk_req_nx;
      mk_done_q   <= mk_done_nx;
      trade_qry_q <= trade_qry_nx;
      upd_vld_q   <= upd_vld_nx;
      rsp_vld_q   <= rsp_vld_nx;
      if (capture) begin
        pop_ask_q <= bus.ask_consumed;
        pop_bid_q <= bus.bid_consumed;
        ask_lm_q  <= bus.trade_kind[1];  // lm_ask_mk_bid
        bid_lm_q  <= bus.trade_kind[0];  // mk_ask_lm_bid
        rem_vld_q <= bus.ask_consumed ^ bus.bid_consumed;
        rem_q     <= bus.remainder;
        qty_q     <= bus.quantity;
        ask_uid_q <= bus.ask_uid;
        bid_uid_q <= bus.bid_uid;
        // a limit bid sets the price against a market ask; otherwise the ask does
        price_q   <= bus.trade_kind[0] ? bus.bid_price : bus.ask_price;
      end
    end
  end

  assign bus.mk_req       = mk_req_q;
  assign bus.mk_done      = mk_done_q;
  assign bus.trade_qry    = trade_qry_q;
  assign bus.upd_vld      = upd_vld_q;
  assign bus.upd_pop_ask  = pop_ask_q;
  assign bus.upd_pop_bid  = pop_bid_q;
  assign bus.upd_ask_lm   = ask_lm_q;
  assign bus.upd_bid_lm   = bid_lm_q;
  assign bus.upd_rem_vld  = rem_vld_q;
  assign bus.upd_rem      = rem_q;
  assign bus.rsp_vld      = rsp_vld_q;
  assign bus.rsp_ask_uid  = ask_uid_q;
  assign bus.rsp_bid_uid  = bid_uid_q;
  assign bus.rsp_price    = price_q;
  assign bus.rsp_quantity = qty_q;
  assign bus.trade_cnt    = cnt_q;
  assign bus.err_r        = err_q;

endmodule

// File: tb/tb_ob_mk_trade_seq.sv
module tb_ob_mk_trade_seq;

  localparam int UID_W   = 32;
  localparam int QTY_W   = 16;
  localparam int PRICE_W = 20;
  localparam int BURST_N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ob_mk_trade_seq_if #(.UID_W(UID_W), .QTY_W(QTY_W), .PRICE_W(PRICE_W)) bus ();

  ob_mk_trade_seq #(
    .UID_W(UID_W), .QTY_W(QTY_W), .PRICE_W(PRICE_W), .BURST_N(BURST_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // from IDLE: raise mk_pending, expect REQ then QRY
  task automatic start_grant();
    bus.mk_pending = 1'b1;
    tick();
    check("mk_req", 32'(bus.mk_req), 32'd1);
    tick();
    check("trade_qry", 32'(bus.trade_qry), 32'd1);
  endtask

  task automatic set_trade(input logic [2:0] kind, input logic ac, input logic bc,
                           input logic [15:0] qty, input logic [15:0] rem,
                           input logic [19:0] ap, input logic [19:0] bp,
                           input logic [31:0] au, input logic [31:0] bu);
    bus.trade_vld_r  = 1'b1;
    bus.trade_kind   = kind;
    bus.ask_consumed = ac;
    bus.bid_consumed = bc;
    bus.quantity     = qty;
    bus.remainder    = rem;
    bus.ask_price    = ap;
    bus.bid_price    = bp;
    bus.ask_uid      = au;
    bus.bid_uid      = bu;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int  trades;
    bit  done_seen;

    bus.mk_pending   = 1'b0;
    bus.mk_gnt       = 1'b1;
    bus.trade_vld_r  = 1'b0;
    bus.trade_kind   = 3'b000;
    bus.ask_uid      = '0;
    bus.bid_uid      = '0;
    bus.ask_price    = '0;
    bus.bid_price    = '0;
    bus.ask_consumed = 1'b0;
    bus.bid_consumed = 1'b0;
    bus.quantity     = '0;
    bus.remainder    = '0;
    bus.upd_ack      = 1'b1;
    bus.rsp_accept   = 1'b1;

    tick();
    tick();
    check("rst_mk_req", 32'(bus.mk_req), 32'd0);
    check("rst_upd_vld", 32'(bus.upd_vld), 32'd0);
    check("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    check("rst_cnt", bus.trade_cnt, 32'd0);
    check("rst_err", 32'(bus.err_r), 32'd0);
    rst = 1'b0;
    tick();

    // 1: mk-mk, both consumed, qty 100; second query returns no trade
    start_grant();
    set_trade(3'b100, 1'b1, 1'b1, 16'd100, 16'd0, 20'h12345, 20'h12400, 32'hA1, 32'hB1);
    tick();
    check("t1_qry_once", 32'(bus.trade_qry), 32'd0);
    tick();
    bus.trade_vld_r = 1'b0;
    check("t1_upd_vld", 32'(bus.upd_vld), 32'd1);
    check("t1_rsp_vld", 32'(bus.rsp_vld), 32'd1);
    check("t1_pop_ask", 32'(bus.upd_pop_ask), 32'd1);
    check("t1_pop_bid", 32'(bus.upd_pop_bid), 32'd1);
    check("t1_rem_vld", 32'(bus.upd_rem_vld), 32'd0);
    check("t1_bid_lm", 32'(bus.upd_bid_lm), 32'd0);
    check("t1_qty", 32'(bus.rsp_quantity), 32'd100);
    check("t1_price", 32'(bus.rsp_price), 32'h12345);
    check("t1_ask_uid", bus.rsp_ask_uid, 32'hA1);
    check("t1_bid_uid", bus.rsp_bid_uid, 32'hB1);
    tick();
    bus.mk_pending = 1'b0;
    check("t1_qry2", 32'(bus.trade_qry), 32'd1);
    check("t1_cnt", bus.trade_cnt, 32'd1);
    check("t1_vld_drop", 32'(bus.rsp_vld), 32'd0);
    tick();
    check("t1_wait_done", 32'(bus.mk_done), 32'd0);
    tick();
    check("t1_done", 32'(bus.mk_done), 32'd1);
    check("t1_req_rel", 32'(bus.mk_req), 32'd0);
    tick();
    check("t1_done_pulse", 32'(bus.mk_done), 32'd0);

    // 2: partial fill, mk_ask_lm_bid
    start_grant();
    set_trade(3'b001, 1'b1, 1'b0, 16'd40, 16'd60, 20'h00500, 20'h00510, 32'hA2, 32'hB2);
    tick();
    tick();
    bus.trade_vld_r = 1'b0;
    bus.mk_pending  = 1'b0;
    check("t2_bid_lm", 32'(bus.upd_bid_lm), 32'd1);
    check("t2_ask_lm", 32'(bus.upd_ask_lm), 32'd0);
    check("t2_pop_ask", 32'(bus.upd_pop_ask), 32'd1);
    check("t2_pop_bid", 32'(bus.upd_pop_bid), 32'd0);
    check("t2_rem_vld", 32'(bus.upd_rem_vld), 32'd1);
    check("t2_rem", 32'(bus.upd_rem), 32'd60);
    check("t2_qty", 32'(bus.rsp_quantity), 32'd40);
    check("t2_price", 32'(bus.rsp_price), 32'h00510);
    tick();
    check("t2_done", 32'(bus.mk_done), 32'd1);
    check("t2_cnt", bus.trade_cnt, 32'd2);
    tick();

    // 3: upd acked at once, rsp held off 5 cycles
    bus.rsp_accept = 1'b0;
    start_grant();
    set_trade(3'b010, 1'b0, 1'b1, 16'd25, 16'd75, 20'h00777, 20'h00780, 32'hA3, 32'hB3);
    tick();
    tick();
    bus.trade_vld_r = 1'b0;
    check("t3_upd_vld", 32'(bus.upd_vld), 32'd1);
    check("t3_rsp_vld", 32'(bus.rsp_vld), 32'd1);
    check("t3_ask_lm", 32'(bus.upd_ask_lm), 32'd1);
    check("t3_price", 32'(bus.rsp_price), 32'h00777);
    tick();
    check("t3_upd_drop", 32'(bus.upd_vld), 32'd0);
    for (int i = 1; i < 6; i++) begin
      check("t3_rsp_hold", 32'(bus.rsp_vld), 32'd1);
      check("t3_qty_stable", 32'(bus.rsp_quantity), 32'd25);
      check("t3_no_qry", 32'(bus.trade_qry), 32'd0);
      check("t3_cnt_hold", bus.trade_cnt, 32'd2);
      if (i == 5) bus.rsp_accept = 1'b1;
      else tick();
    end
    tick();
    bus.mk_pending = 1'b0;
    check("t3_rsp_drop", 32'(bus.rsp_vld), 32'd0);
    check("t3_qry_next", 32'(bus.trade_qry), 32'd1);
    check("t3_cnt", bus.trade_cnt, 32'd3);
    tick();
    tick();
    check("t3_done", 32'(bus.mk_done), 32'd1);
    tick();

    // 4: burst limit with every query valid and mk_pending held
    start_grant();
    set_trade(3'b100, 1'b1, 1'b1, 16'd10, 16'd0, 20'h00100, 20'h00100, 32'hA4, 32'hB4);
    trades    = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      if (bus.rsp_vld) trades++;
      if (bus.mk_done) done_seen = 1'b1;
      else tick();
    end
    check("t4_done_seen", 32'(done_seen), 32'd1);
    check("t4_trades", 32'(trades), 32'(BURST_N));
    check("t4_cnt", bus.trade_cnt, 32'd7);
    check("t4_req_rel", 32'(bus.mk_req), 32'd0);
    bus.trade_vld_r = 1'b0;
    tick();
    check("t4_idle_req", 32'(bus.mk_req), 32'd0);
    tick();
    check("t4_fresh_req", 32'(bus.mk_req), 32'd1);
    bus.mk_pending = 1'b0;
    tick();
    tick();
    tick();
    check("t4_done2", 32'(bus.mk_done), 32'd1);
    tick();

    // 5: protocol error, neither side consumed
    start_grant();
    bus.mk_pending = 1'b0;
    set_trade(3'b100, 1'b0, 1'b0, 16'd5, 16'd5, 20'h00200, 20'h00200, 32'hA5, 32'hB5);
    tick();
    tick();
    bus.trade_vld_r = 1'b0;
    check("t5_done", 32'(bus.mk_done), 32'd1);
    check("t5_no_upd", 32'(bus.upd_vld), 32'd0);
    check("t5_no_rsp", 32'(bus.rsp_vld), 32'd0);
    check("t5_err", 32'(bus.err_r), 32'd1);
    check("t5_cnt", bus.trade_cnt, 32'd7);
    tick();
    tick();
    check("t5_err_sticky", 32'(bus.err_r), 32'd1);

    // 6: async reset while EMIT is stalled
    bus.upd_ack    = 1'b0;
    bus.rsp_accept = 1'b0;
    start_grant();
    set_trade(3'b100, 1'b1, 1'b1, 16'd9, 16'd0, 20'h00300, 20'h00300, 32'hA6, 32'hB6);
    tick();
    tick();
    bus.trade_vld_r = 1'b0;
    bus.mk_pending  = 1'b0;
    check("t6_rsp_vld", 32'(bus.rsp_vld), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_rsp", 32'(bus.rsp_vld), 32'd0);
    check("t6_rst_upd", 32'(bus.upd_vld), 32'd0);
    check("t6_rst_req", 32'(bus.mk_req), 32'd0);
    check("t6_rst_cnt", bus.trade_cnt, 32'd0);
    check("t6_rst_err", 32'(bus.err_r), 32'd0);
    check("t6_rst_done", 32'(bus.mk_done), 32'd0);
    tick();
    rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.mk_done) done_seen = 1'b1;
    end
    check("t6_no_done", 32'(done_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ob_mk_trade_seq.md
# ob_mk_trade_seq

Sequencer for the market-order trade datapath. It sits between the order-book top-level controller and the market/limit trade decision logic. Once the top-level grants it ownership of the tables, it issues trade queries and captures each registered trade result. It then commands the table/queue update and emits one trade record per match to egress, running up to a bounded burst of trades per grant.

## Interface
- `UID_W`, 32, order UID width
- `QTY_W`, 16, quantity width
- `PRICE_W`, 20, BCD price width
- `BURST_N`, 4, max trades per grant (≥1)

Ports:
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  reset; asynchronous, active-high
- `mk_pending`  in  1  either market queue non-empty
- `mk_req`  out  1  request table ownership from top-level controller
- `mk_gnt`  in  1  ownership granted; held high by top-level until `mk_done`
- `mk_done`  out  1  one-cycle pulse: ownership released
- `trade_qry`  out  1  one-cycle query to decision logic
- `trade_vld_r`  in  1  decision result valid; registered, arrives exactly 1 cycle after `trade_qry`
- `trade_kind`  in  3  one-hot {mk_ask_mk_bid, lm_ask_mk_bid, mk_ask_lm_bid}
- `ask_uid`, `bid_uid`  in  UID_W  matched order UIDs
- `ask_price`, `bid_price`  in  PRICE_W  side prices
- `ask_consumed`, `bid_consumed`  in  1  side fully filled
- `quantity`, `remainder`  in  QTY_W  traded quantity; residual on the surviving side
- `upd_vld`  out  1  table update command valid
- `upd_ack`  in  1  update accepted
- `upd_pop_ask`, `upd_pop_bid`  out  1  pop the consumed head
- `upd_ask_lm`, `upd_bid_lm`  out  1  per side, 1 = limit table, 0 = market queue
- `upd_rem_vld`  out  1  rewrite the surviving head quantity with `upd_rem`
- `upd_rem`  out  QTY_W  remainder value
- `rsp_vld`  out  1  trade record valid
- `rsp_accept`  in  1  egress accepts
- `rsp_ask_uid`, `rsp_bid_uid`  out  UID_W  record UIDs
- `rsp_price`  out  PRICE_W  execution price
- `rsp_quantity`  out  QTY_W  executed quantity
- `trade_cnt`  out  32  completed-trade counter
- `err_r`  out  1  sticky protocol error

## Operation
- FSM states: IDLE, REQ, QRY, WAIT, EMIT, REL.
- IDLE → REQ when `mk_pending`.
- REQ: `mk_req`=1. Moves to QRY when `mk_gnt` is sampled high. `mk_gnt` is sampled only in REQ.
- QRY: `trade_qry`=1 for exactly one cycle. Always moves to WAIT.
- WAIT: samples `trade_vld_r`.
  - High: capture all trade fields into holding registers, clear the per-channel done flags, go to EMIT.
  - Low: go to REL.
- EMIT: `upd_vld` and `rsp_vld` assert together. Each channel drops independently on its own ack (`upd_ack` / `rsp_accept`), and each channel's done flag sets on its handshake.
  - When both are done: `trade_cnt` += 1 and burst count += 1.
  - Then go to QRY if burst count < BURST_N and `mk_pending`; otherwise go to REL.
- REL: `mk_done`=1 for one cycle, `mk_req`=0, burst count cleared, go to IDLE.
- Update fields come from the held trade:
  - `upd_pop_ask` = `ask_consumed`; `upd_pop_bid` = `bid_consumed`.
  - `upd_ask_lm` = lm_ask_mk_bid; `upd_bid_lm` = mk_ask_lm_bid.
  - `upd_rem_vld` = `ask_consumed` XOR `bid_consumed`; `upd_rem` = `remainder`.
- Execution price:
  - mk_ask_lm_bid → `bid_price`.
  - lm_ask_mk_bid → `ask_price`.
  - mk_ask_mk_bid → `ask_price`.
- Protocol errors set `err_r`, and the FSM goes to REL without emitting:
  - a captured trade with neither side consumed;
  - a `trade_kind` that is not one-hot.
- `err_r` clears only on `rst`.
- `trade_vld_r` outside WAIT is ignored.
- `trade_cnt` wraps from 2^32−1 to 0.

## Timing
- All outputs are registered. Reset values: all outputs 0, state IDLE.
- Cycle-level sequence (cycle n = `mk_pending` sampled in IDLE):
  - n+1: `mk_req`=1.
  - Same-cycle `mk_gnt` → n+2: `trade_qry`.
  - n+3: WAIT samples `trade_vld_r`.
  - n+4: `upd_vld`/`rsp_vld`.
- With immediate acks, the next `trade_qry` issues at n+5, giving a 3-cycle trade period.
- No-trade path: WAIT → REL → IDLE; `mk_done` asserts 2 cycles after `trade_qry`.
- `rsp_*`/`upd_*` fields are stable while their valid is high; valid never drops without its ack.
- Async `rst` mid-operation: immediate return to IDLE. The held trade is discarded, no `mk_done` is issued, and `trade_cnt`/`err_r` clear.

## Test plan
- **Single mk–mk trade, equal quantities.** Inputs: gnt same cycle; trade_vld_r with ask_qty=bid_qty=100. Required: `upd_pop_ask`=`upd_pop_bid`=1, `upd_rem_vld`=0, `rsp_quantity`=100, `rsp_price`=`ask_price`, `trade_cnt`=1, `mk_done` 2 cycles after the second, invalid query.
- **Partial fill, mk_ask_lm_bid.** Inputs: bid_consumed=0, ask_consumed=1, quantity=40, remainder=60. Required: `upd_bid_lm`=1, `upd_pop_ask`=1, `upd_rem_vld`=1, `upd_rem`=60, `rsp_price`=`bid_price`.
- **Independent backpressure.** Inputs: `upd_ack` at cycle +0, `rsp_accept` held off 5 cycles. Required: `upd_vld` drops after 1 cycle; `rsp_vld` holds stable 6 cycles; next `trade_qry` only after accept; counter increments once.
- **Burst limit.** Inputs: BURST_N=4, `mk_pending` held high, every query valid. Required: exactly 4 trades, then `mk_done`, then a fresh `mk_req` cycle.
- **Protocol error.** Inputs: trade with both consumed=0. Required: no `upd_vld`/`rsp_vld`, `err_r`=1 sticky, `mk_done` pulse.
- **Async reset while in EMIT with `rsp_vld` high.** Required: all outputs 0 immediately, `trade_cnt`=0, no `mk_done`.
